// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ahb_pkg
// Description : Shared AHB-Lite definitions for the uio responder: transfer
//               type encoding, hsize / hresp constants and the responder
//               state encoding (also used by the testbench).
// Revision    : 1.0 - initial release
// ============================================================================
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_WR      = 3'd2,
        ST_TURN    = 3'd3,
        ST_RD_DONE = 3'd4,
        ST_ERR1    = 3'd5,
        ST_ERR2    = 3'd6
    } resp_state_t;

endpackage
`default_nettype wire

// File: rtl/ahb_uio_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : ahb_uio_responder_if
// Description : AHB-Lite bus bundle between the dcache master and the uio
//               responder.
//   master modport : drives hsel, haddr, htrans, hwrite, hsize, hwdata
//                    samples hrdata, hready, hresp
//   slave  modport : the reverse
// Revision    : 1.0 - initial release
// ============================================================================
interface ahb_uio_responder_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    import ahb_pkg::*;

    logic              hsel;
    logic [ADDR_W-1:0] haddr;
    htrans_t           htrans;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [DATA_W-1:0] hwdata;
    logic [DATA_W-1:0] hrdata;
    logic              hready;
    logic              hresp;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hwdata,
        input  hrdata, hready, hresp
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hwdata,
        output hrdata, hready, hresp
    );

endinterface
`default_nettype wire

// File: rtl/ahb_wait_counter.sv
`default_nettype none
// ============================================================================
// Module      : ahb_wait_counter
// Description : Loadable 4-bit down-counter with a done flag. Load wins over
//               count; the counter parks at zero.
//   clk, rst_n  : clock, asynchronous active-low reset
//   load_i      : load load_val_i this cycle
//   load_val_i  : value to load
//   en_i        : count down by one (when not loading and not zero)
//   done_o      : count is zero
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_wait_counter (
    input  wire        clk,
    input  wire        rst_n,
    input  wire        load_i,
    input  wire  [3:0] load_val_i,
    input  wire        en_i,
    output logic       done_o
);

    logic [3:0] count_q;
    logic [3:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != 4'd0)) begin
            count_d = count_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == 4'd0);

endmodule
`default_nettype wire

// File: rtl/ahb_uio_responder.sv
`default_nettype none
// ============================================================================
// Module      : ahb_uio_responder
// Description : AHB-Lite responder that turns single-byte transfers into a
//               multiplexed address/data transaction on the 8-bit uio pins,
//               stretching the data phase with hready.
//   clk, rst_n      : clock, asynchronous active-low reset
//   bus (slave)     : AHB-Lite hsel/haddr/htrans/hwrite/hsize/hwdata in,
//                     hrdata/hready/hresp out
//   ext_in          : uio input path (read data from the device)
//   ext_out, ext_oe : uio output path and per-pin output enable
//   ext_ale, ext_we : address-latch and write strobes
// Optional build macro AHB_UIO_ERR_RESP_EN: non-byte transfers receive the
// two-cycle ERROR response instead of being treated as byte accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_uio_responder
    import ahb_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  wire              clk,
    input  wire              rst_n,
    ahb_uio_responder_if.slave bus,
    input  wire        [7:0] ext_in,
    output logic       [7:0] ext_out,
    output logic       [7:0] ext_oe,
    output logic             ext_ale,
    output logic             ext_we
);

    generate
        if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
            $error("ahb_uio_responder: WAIT_CYCLES must be in 1..15");
        end
        if (DATA_W != 8 || ADDR_W < 8) begin : g_bad_width
            $error("ahb_uio_responder: DATA_W must be 8 and ADDR_W at least 8");
        end
    endgenerate

    // Counter preload so that TURN lasts exactly WAIT_CYCLES cycles.
    localparam logic [3:0] C_TURN_LOAD = 4'(WAIT_CYCLES - 1);

    resp_state_t       state_q;
    resp_state_t       state_d;
    resp_state_t       w_accept_next;
    logic [7:0]        addr_q;
    logic [7:0]        wdata_q;
    logic              write_q;
    logic [DATA_W-1:0] hrdata_q;

    logic w_accept;
    logic w_size_err;
    logic w_cnt_load;
    logic w_cnt_en;
    logic w_cnt_done;
    logic w_hready;
    logic w_hresp;
    logic w_unused;

    // Only a NONSEQ/SEQ address phase seen while ready starts a transfer.
    assign w_accept = bus.hsel && bus.htrans[1] && w_hready;

`ifdef AHB_UIO_ERR_RESP_EN
    assign w_size_err = (bus.hsize != HSIZE_BYTE);
`else
    assign w_size_err = 1'b0;
`endif

    // Destination from any cycle with hready=1 (IDLE or a completion cycle).
    assign w_accept_next = !w_accept ? ST_IDLE : (w_size_err ? ST_ERR1 : ST_ADDR);

    // Bits of the bus that do not reach the pins in every build.
    assign w_unused = ^{bus.haddr, bus.htrans, bus.hsize};

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE,
            ST_WR,
            ST_RD_DONE: state_d = w_accept_next;
            ST_ADDR:    state_d = write_q ? ST_WR : ST_TURN;
            ST_TURN:    if (w_cnt_done) state_d = ST_RD_DONE;
`ifdef AHB_UIO_ERR_RESP_EN
            ST_ERR1:    state_d = ST_ERR2;
            ST_ERR2:    state_d = w_accept_next;
`endif
            default:    state_d = ST_IDLE;
        endcase
    end

    // --------------------------------------------------------------- outputs
    always_comb begin
        w_hready = 1'b1;
        w_hresp  = HRESP_OKAY;
        ext_out  = 8'h00;
        ext_oe   = 8'h00;
        ext_ale  = 1'b0;
        ext_we   = 1'b0;
        case (state_q)
            ST_ADDR: begin
                w_hready = 1'b0;
                ext_oe   = 8'hFF;
                ext_out  = addr_q;
                ext_ale  = 1'b1;
            end
            ST_WR: begin
                ext_oe   = 8'hFF;
                ext_out  = wdata_q;
                ext_we   = 1'b1;
            end
            // Pins released for the whole turnaround before ext_in is sampled.
            ST_TURN: w_hready = 1'b0;
`ifdef AHB_UIO_ERR_RESP_EN
            ST_ERR1: begin
                w_hready = 1'b0;
                w_hresp  = HRESP_ERROR;
            end
            ST_ERR2: w_hresp = HRESP_ERROR;
`endif
            default: ;
        endcase
    end

    // -------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= 8'h00;
            write_q  <= 1'b0;
            wdata_q  <= 8'h00;
            hrdata_q <= '0;
        end else begin
            if (w_accept) begin
                addr_q  <= bus.haddr[7:0];
                write_q <= bus.hwrite;
            end
            // hwdata belongs to the data phase, which is the ADDR cycle here.
            if (state_q == ST_ADDR) begin
                wdata_q <= bus.hwdata[7:0];
            end
            // Sampled on the edge that leaves the last TURN cycle; held after.
            if ((state_q == ST_TURN) && w_cnt_done) begin
                hrdata_q <= ext_in;
            end
        end
    end

    assign w_cnt_load = (state_q == ST_ADDR) && !write_q;
    assign w_cnt_en   = (state_q == ST_TURN);

    ahb_wait_counter u_turn_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (w_cnt_load),
        .load_val_i (C_TURN_LOAD),
        .en_i       (w_cnt_en),
        .done_o     (w_cnt_done)
    );

    assign bus.hrdata = hrdata_q;
    assign bus.hready = w_hready;
    assign bus.hresp  = w_hresp;

endmodule
`default_nettype wire

// File: tb/tb_ahb_uio_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_uio_responder
// Description : Self-checking bench for ahb_uio_responder. Expected pin and
//               bus behaviour comes from the transfer rules: a write shows
//               one address cycle then one strobed data cycle, a read shows
//               one address cycle, WC released cycles and a done cycle, and
//               hrdata holds the last completed read.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_uio_responder;
    import ahb_pkg::*;

    localparam int WC    = 2;
    localparam int NRAND = 40;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ext_in = 8'h00;
    logic [7:0] ext_out;
    logic [7:0] ext_oe;
    logic       ext_ale;
    logic       ext_we;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_rdata = 8'h00;

    ahb_uio_responder_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    ahb_uio_responder #(
        .ADDR_W      (8),
        .DATA_W      (8),
        .WAIT_CYCLES (WC)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .ext_in  (ext_in),
        .ext_out (ext_out),
        .ext_oe  (ext_oe),
        .ext_ale (ext_ale),
        .ext_we  (ext_we)
    );

    always #5 clk = ~clk;

    // {hready, hresp, ext_oe, ext_ale, ext_we}
    wire [11:0] ctl = {bus.hready, bus.hresp, ext_oe, ext_ale, ext_we};

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.hsel   = 1'b0;
        bus.htrans = HTRANS_IDLE;
        bus.hwrite = 1'b0;
        bus.haddr  = 8'h00;
        bus.hsize  = HSIZE_BYTE;
        bus.hwdata = 8'h00;
    endtask

    task automatic addr_phase(input logic wr, input logic [7:0] a, input logic [2:0] sz);
        bus.hsel   = 1'b1;
        bus.htrans = HTRANS_NONSEQ;
        bus.hwrite = wr;
        bus.haddr  = a;
        bus.hsize  = sz;
    endtask

    // Runs one read from the current (ready) cycle until hready returns,
    // reporting what was observed; the callers judge it.
    task automatic run_read(input logic [7:0] a, input logic [7:0] d, input logic [2:0] sz,
                            output int low, output int oe_turn, output int ale_cnt,
                            output logic [7:0] first_out);
        addr_phase(1'b0, a, sz);
        low = 0; oe_turn = 0; ale_cnt = 0; first_out = 8'h00;
        for (int k = 0; k < 20; k++) begin
            next_cycle();
            bus.hsel   = 1'b0;
            bus.htrans = HTRANS_IDLE;
            ext_in     = d;
            @(negedge clk);
            if (bus.hready) break;
            if (k == 0) first_out = ext_out;
            if (ext_ale) ale_cnt++;
            if (k > 0 && ext_oe != 8'h00) oe_turn++;
            low++;
        end
    endtask

    task automatic test_reset();
        bus_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({ctl, ext_out, bus.hrdata} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00}) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h", {ctl, ext_out, bus.hrdata},
                     {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00});
        end
        checks++;
        if (dut.state_q !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d expected %0d", dut.state_q, ST_IDLE);
        end
        rst_n = 1'b1;
        exp_rdata = 8'h00;
    endtask

    task automatic test_write();
        logic [19:0] exp;
        addr_phase(1'b1, 8'h15, HSIZE_BYTE);
        next_cycle();
        bus.hwdata = 8'hA5;
        bus.hsel   = 1'b0;
        bus.htrans = HTRANS_IDLE;
        @(negedge clk);
        exp = {1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 8'h15};
        checks++;
        if ({ctl, ext_out} !== exp) begin
            errors++;
            $display("FAIL write_addr_cycle: got %h expected %h", {ctl, ext_out}, exp);
        end
        next_cycle();
        @(negedge clk);
        exp = {1'b1, 1'b0, 8'hFF, 1'b0, 1'b1, 8'hA5};
        checks++;
        if ({ctl, ext_out} !== exp) begin
            errors++;
            $display("FAIL write_data_cycle: got %h expected %h", {ctl, ext_out}, exp);
        end
        checks++;
        if (bus.hrdata !== exp_rdata) begin
            errors++;
            $display("FAIL write_keeps_hrdata: got %h expected %h", bus.hrdata, exp_rdata);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (ctl !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL write_then_idle: got %h expected %h", ctl, {1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
        end
    endtask

    task automatic test_read();
        int low, oet, ale;
        logic [7:0] fo;
        run_read(8'h0C, 8'h69, HSIZE_BYTE, low, oet, ale, fo);
        checks++;
        if (low !== 1 + WC) begin
            errors++;
            $display("FAIL read_wait_cycles: got %0d expected %0d", low, 1 + WC);
        end
        checks++;
        if ({oet, ale, fo} !== {32'd0, 32'd1, 8'h0C}) begin
            errors++;
            $display("FAIL read_pins: got oe_turn=%0d ale=%0d addr=%h expected 0 1 0c", oet, ale, fo);
        end
        checks++;
        if ({bus.hready, bus.hresp, bus.hrdata} !== {1'b1, 1'b0, 8'h69}) begin
            errors++;
            $display("FAIL read_done: got %h expected %h", {bus.hready, bus.hresp, bus.hrdata},
                     {1'b1, 1'b0, 8'h69});
        end
        exp_rdata = 8'h69;
    endtask

    task automatic test_back_to_back();
        int low, oet, ale;
        logic [7:0] fo;
        logic [7:0] rd;
        logic [7:0] wd;
        logic [19:0] exp;
        rd = 8'($urandom);
        wd = 8'($urandom);
        run_read(8'h01, rd, HSIZE_BYTE, low, oet, ale, fo);
        checks++;
        if ({low, bus.hrdata} !== {1 + WC, rd}) begin
            errors++;
            $display("FAIL b2b_read: got low=%0d data=%h expected %0d %h", low, bus.hrdata, 1 + WC, rd);
        end
        exp_rdata = rd;
        addr_phase(1'b1, 8'h02, HSIZE_BYTE);
        next_cycle();
        bus.hwdata = wd;
        bus.hsel   = 1'b0;
        bus.htrans = HTRANS_IDLE;
        @(negedge clk);
        exp = {1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 8'h02};
        checks++;
        if ({ctl, ext_out} !== exp) begin
            errors++;
            $display("FAIL b2b_addr_no_gap: got %h expected %h", {ctl, ext_out}, exp);
        end
        next_cycle();
        @(negedge clk);
        exp = {1'b1, 1'b0, 8'hFF, 1'b0, 1'b1, wd};
        checks++;
        if ({ctl, ext_out} !== exp) begin
            errors++;
            $display("FAIL b2b_write_data: got %h expected %h", {ctl, ext_out}, exp);
        end
    endtask

    task automatic test_idle_traffic();
        for (int k = 0; k < 6; k++) begin
            bus.haddr  = 8'($urandom);
            bus.hwrite = 1'($urandom);
            case (k % 3)
                0:       begin bus.hsel = 1'b1; bus.htrans = HTRANS_BUSY;   end
                1:       begin bus.hsel = 1'b0; bus.htrans = HTRANS_NONSEQ; end
                default: begin bus.hsel = 1'b1; bus.htrans = HTRANS_IDLE;   end
            endcase
            next_cycle();
            @(negedge clk);
            checks++;
            if (ctl !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL idle_traffic_%0d: got %h expected %h", k, ctl, {1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
            end
        end
        bus_idle();
    endtask

    task automatic test_error_resp();
`ifdef AHB_UIO_ERR_RESP_EN
        logic [19:0] exp;
        ext_in = 8'h5A;
        addr_phase(1'b0, 8'h33, HSIZE_WORD);
        next_cycle();
        bus_idle();
        @(negedge clk);
        checks++;
        if (ctl !== {1'b0, 1'b1, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL err_first_cycle: got %h expected %h", ctl, {1'b0, 1'b1, 8'h00, 1'b0, 1'b0});
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if ({ctl, bus.hrdata} !== {1'b1, 1'b1, 8'h00, 1'b0, 1'b0, exp_rdata}) begin
            errors++;
            $display("FAIL err_second_cycle: got %h expected %h", {ctl, bus.hrdata},
                     {1'b1, 1'b1, 8'h00, 1'b0, 1'b0, exp_rdata});
        end
        // New byte write accepted in the second error cycle.
        addr_phase(1'b1, 8'h44, HSIZE_BYTE);
        next_cycle();
        bus.hwdata = 8'h7E;
        bus.hsel   = 1'b0;
        bus.htrans = HTRANS_IDLE;
        @(negedge clk);
        exp = {1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 8'h44};
        checks++;
        if ({ctl, ext_out} !== exp) begin
            errors++;
            $display("FAIL err_then_addr: got %h expected %h", {ctl, ext_out}, exp);
        end
        next_cycle();
        @(negedge clk);
        exp = {1'b1, 1'b0, 8'hFF, 1'b0, 1'b1, 8'h7E};
        checks++;
        if ({ctl, ext_out} !== exp) begin
            errors++;
            $display("FAIL err_then_write: got %h expected %h", {ctl, ext_out}, exp);
        end
`else
        int low, oet, ale;
        logic [7:0] fo;
        run_read(8'h33, 8'h5A, HSIZE_WORD, low, oet, ale, fo);
        checks++;
        if ({low, ale, fo} !== {1 + WC, 32'd1, 8'h33}) begin
            errors++;
            $display("FAIL word_as_byte_read: got low=%0d ale=%0d addr=%h expected %0d 1 33", low, ale, fo, 1 + WC);
        end
        checks++;
        if ({bus.hready, bus.hresp, bus.hrdata} !== {1'b1, 1'b0, 8'h5A}) begin
            errors++;
            $display("FAIL word_as_byte_done: got %h expected %h", {bus.hready, bus.hresp, bus.hrdata},
                     {1'b1, 1'b0, 8'h5A});
        end
        exp_rdata = 8'h5A;
`endif
    endtask

    task automatic test_reset_mid();
        int low, oet, ale;
        logic [7:0] fo;
        ext_in = 8'hC3;
        addr_phase(1'b0, 8'h0C, HSIZE_BYTE);
        next_cycle();          // address/ale cycle
        bus_idle();
        next_cycle();          // first turnaround cycle
        next_cycle();          // second turnaround cycle
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({ctl, bus.hrdata} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %h expected %h", {ctl, bus.hrdata},
                     {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00});
        end
        checks++;
        if (dut.state_q !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_mid_state: got %0d expected %0d", dut.state_q, ST_IDLE);
        end
        rst_n = 1'b1;
        exp_rdata = 8'h00;
        run_read(8'h0C, 8'h96, HSIZE_BYTE, low, oet, ale, fo);
        checks++;
        if ({low, ale, fo, bus.hready, bus.hrdata} !== {1 + WC, 32'd1, 8'h0C, 1'b1, 8'h96}) begin
            errors++;
            $display("FAIL reset_mid_reread: got low=%0d ale=%0d addr=%h data=%h expected %0d 1 0c 96",
                     low, ale, fo, bus.hrdata, 1 + WC);
        end
        exp_rdata = 8'h96;
    endtask

    task automatic test_random();
        logic       wr;
        logic [7:0] a;
        logic [7:0] d;
        int         gap;
        for (int n = 0; n < NRAND; n++) begin
            wr  = 1'($urandom);
            a   = 8'($urandom);
            d   = 8'($urandom);
            gap = int'($urandom_range(0, 2));
            addr_phase(wr, a, HSIZE_BYTE);
            bus.htrans = (($urandom & 1) != 0) ? HTRANS_SEQ : HTRANS_NONSEQ;
            next_cycle();
            bus.hwdata = wr ? d : 8'($urandom);
            // Bus noise while hready is low must not be taken as a transfer.
            bus.hsel   = 1'($urandom);
            bus.htrans = htrans_t'(2'($urandom));
            bus.haddr  = 8'($urandom);
            ext_in     = 8'($urandom);
            @(negedge clk);
            checks++;
            if ({ctl, ext_out} !== {1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, a}) begin
                errors++;
                $display("FAIL rnd_addr_cycle[%0d]: got %h expected %h", n, {ctl, ext_out},
                         {1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, a});
            end
            if (wr) begin
                next_cycle();
                @(negedge clk);
                checks++;
                if ({ctl, ext_out, bus.hrdata} !== {1'b1, 1'b0, 8'hFF, 1'b0, 1'b1, d, exp_rdata}) begin
                    errors++;
                    $display("FAIL rnd_write_cycle[%0d]: got %h expected %h", n, {ctl, ext_out, bus.hrdata},
                             {1'b1, 1'b0, 8'hFF, 1'b0, 1'b1, d, exp_rdata});
                end
            end else begin
                for (int t = 0; t < WC; t++) begin
                    next_cycle();
                    ext_in     = (t == WC - 1) ? d : 8'($urandom);
                    bus.hsel   = 1'($urandom);
                    bus.htrans = htrans_t'(2'($urandom));
                    @(negedge clk);
                    checks++;
                    if ({ctl, bus.hrdata} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, exp_rdata}) begin
                        errors++;
                        $display("FAIL rnd_turn[%0d.%0d]: got %h expected %h", n, t, {ctl, bus.hrdata},
                                 {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, exp_rdata});
                    end
                end
                next_cycle();
                ext_in = 8'($urandom);
                @(negedge clk);
                checks++;
                if ({bus.hready, bus.hresp, bus.hrdata} !== {1'b1, 1'b0, d}) begin
                    errors++;
                    $display("FAIL rnd_read_done[%0d]: got %h expected %h", n,
                             {bus.hready, bus.hresp, bus.hrdata}, {1'b1, 1'b0, d});
                end
                exp_rdata = d;
            end
            bus_idle();
            for (int g = 0; g < gap; g++) begin
                bus.haddr = 8'($urandom);
                case ($urandom_range(0, 2))
                    0:       begin bus.hsel = 1'b0; bus.htrans = HTRANS_NONSEQ; end
                    1:       begin bus.hsel = 1'b1; bus.htrans = HTRANS_BUSY;   end
                    default: begin bus.hsel = 1'b1; bus.htrans = HTRANS_IDLE;   end
                endcase
                next_cycle();
                @(negedge clk);
                checks++;
                if (ctl !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
                    errors++;
                    $display("FAIL rnd_idle[%0d.%0d]: got %h expected %h", n, g, ctl,
                             {1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
                end
            end
        end
        bus_idle();
    endtask

    initial begin
        bus_idle();
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_idle_traffic();
        test_error_resp();
        test_reset_mid();
        test_random();
        next_cycle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ahb_uio_responder.md
Name: ahb_uio_responder

Overview:
- AHB-Lite subordinate (responder): the target side of the AHB master interface driven by the dcache controller.
- Accepts single-byte AHB transfers and turns each one into a multiplexed transaction on the 8-bit bidirectional uio pins.
- Inserts wait states via hready.
- Replaces the ad-hoc memory stub in the tt_um top level; the top level wires its AHB nets and uio pins straight to this block.

Parameters:
- ADDR_W, 8, AHB address width; only haddr[7:0] reaches the pins.
- DATA_W, 8, data width; fixed at 8 for this design.
- WAIT_CYCLES, 2, bus-turnaround/wait cycles for a read. Legal range 1..15; an elaboration-time assertion rejects 0.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low; clock clk
- hsel  in  1  subordinate select
- haddr  in  ADDR_W  AHB address
- htrans  in  2  transfer type (IDLE/BUSY/NONSEQ/SEQ)
- hwrite  in  1  1 = write
- hsize  in  3  transfer size
- hwdata  in  DATA_W  write data (valid in the data phase)
- hrdata  out  DATA_W  read data
- hready  out  1  transfer done / subordinate ready
- hresp  out  1  0 = OKAY, 1 = ERROR
- ext_in  in  8  uio input path
- ext_out  out  8  uio output path
- ext_oe  out  8  uio output enable
- ext_ale  out  1  address-latch strobe to the external device
- ext_we  out  1  write strobe to the external device

Behaviour:
- Reset values: state IDLE, hready=1, hresp=0, hrdata=8'h00, ext_out=8'h00, ext_oe=8'h00, ext_ale=0, ext_we=0, wait counter=0.
- Address-phase accept: hsel && htrans[1] && hready at a rising edge. On accept, latch haddr[7:0], hwrite, hsize.
- IDLE/BUSY transfers, and any cycle with hsel=0, get a zero-wait OKAY (hready=1, hresp=0) and no pin activity.
- States: IDLE, ADDR, WR, TURN, RD_DONE, ERR1, ERR2.
- IDLE: hready=1. On accept -> ADDR.
- ADDR: hready=0, ext_oe=FF, ext_out=latched addr, ext_ale=1. Capture hwdata this cycle. Next state: WR if write, TURN if read.
- WR: hready=1, ext_oe=FF, ext_out=captured wdata, ext_we=1.
- TURN: hready=0, ext_oe=00. Stays WAIT_CYCLES cycles (counter loads WAIT_CYCLES-1 on entry and counts down to 0). hrdata is registered from ext_in on the edge leaving the final TURN cycle; it is held until the next read completes.
- RD_DONE: hready=1, hresp=0, hrdata valid.
- Completion cycles (WR, RD_DONE, ERR2) have hready=1. A new address phase accepted in that same cycle goes directly to ADDR (back-to-back pipelining); otherwise -> IDLE.
- Latency, counted from the first data-phase cycle: write = 2 cycles (1 wait state); read = 2 + WAIT_CYCLES cycles.
- ext_oe is never FF in the cycle immediately after a TURN entry. The bus is always released for at least one cycle before sampling.
- Writes ignore hrdata; hrdata keeps its last read value.
- hsel deasserted mid data phase is ignored; the transfer in flight completes.
- htrans changing while hready=0 is ignored; the master is required to hold it.
- Reset mid-transfer: immediate return to reset values and the bus is released (ext_oe=00). No strobe glitch beyond the reset edge.

Optional Feature:
- Macro: AHB_UIO_ERR_RESP_EN.
- Defined: an accepted transfer with hsize != 3'b000 does no pin activity and goes ERR1 -> ERR2, following the AHB two-cycle error response.
  - ERR1: hready=0, hresp=1.
  - ERR2: hready=1, hresp=1.
  - Then IDLE, or ADDR if a new transfer is accepted in ERR2.
- Not defined: hsize is ignored, every transfer is handled as a byte access, ERR states are not built, and hresp is tied 0.

Decomposition:
- Shared package ahb_pkg holds:
  - htrans_t enum: IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11.
  - hsize constants: HSIZE_BYTE=3'b000, HSIZE_HALF=3'b001, HSIZE_WORD=3'b010.
  - HRESP_OKAY=1'b0, HRESP_ERROR=1'b1.
  - The responder state enum (shared with the bench for coverage).
- One natural sub-module: ahb_wait_counter. Loadable 4-bit down-counter with a done flag, reused later for write wait states.

Test Plan:
- Write: NONSEQ write haddr=8'h15, hwdata=8'hA5, WAIT_CYCLES=2 -> ADDR cycle shows ext_out=8'h15, ext_ale=1, hready=0; next cycle ext_out=8'hA5, ext_we=1, hready=1, hresp=0.
- Read: NONSEQ read haddr=8'h0C, ext_in=8'h69 -> hready low for exactly 3 cycles (ADDR + 2 TURN); ext_oe=00 throughout TURN; RD_DONE shows hrdata=8'h69, hready=1.
- Back-to-back: read 8'h01 immediately followed by write 8'h02 (next NONSEQ presented in the RD_DONE cycle) -> ADDR for 8'h02 in the following cycle with no IDLE gap.
- Idle traffic: htrans=BUSY, or hsel=0 with htrans=NONSEQ -> hready stays 1, ext_oe=00, no strobes.
- Error response: with AHB_UIO_ERR_RESP_EN, read with hsize=3'b010 -> ERR1 (hready=0, hresp=1) then ERR2 (hready=1, hresp=1), no ext_ale. Without the macro, the same stimulus completes as a normal byte read.
- Reset during operation: rst_n asserted during the second TURN cycle -> next sample shows ext_oe=00, hready=1, hresp=0, state IDLE; a subsequent read at 8'h0C completes normally.
